// File: rtl/jellyvl_etherneco_forwarder_pkg.sv
// Shared types for the etherneco packet forwarder:
// FIFO entry layout and the receive-side write state.
package jellyvl_etherneco_forwarder_pkg;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       dest;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/jellyvl_etherneco_packet_fifo.sv
// Commit/rollback byte FIFO: the reader only sees committed packets.
// Ports: wr_en/wr_entry write, commit publishes, rollback rewinds the
// speculative write pointer; rd_entry/rd_valid/rd_ready pop side;
// full/commit_full are pre-pop fill flags, pending = committed data held.
module jellyvl_etherneco_packet_fifo
    import jellyvl_etherneco_forwarder_pkg::*;
#(
    parameter int PTR_WIDTH = 10
) (
    input  logic        reset,
    input  logic        clk,
    input  logic        wr_en,
    input  fifo_entry_t wr_entry,
    input  logic        commit,
    input  logic        rollback,
    output logic        full,
    output logic        commit_full,
    output logic        pending,
    output fifo_entry_t rd_entry,
    output logic        rd_valid,
    input  logic        rd_ready
);

    localparam int DEPTH = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] FULL_DIFF = {1'b1, {PTR_WIDTH{1'b0}}};
    localparam logic [PTR_WIDTH:0] PTR_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] commit_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic [PTR_WIDTH:0] rd_limit;
    logic [PTR_WIDTH:0] wr_base;
    logic [PTR_WIDTH:0] wr_ptr_next;

    fifo_entry_t mem [DEPTH];

    // A rollback may coincide with the first byte of a new packet,
    // which then lands at the rewound position.
    assign wr_base     = rollback ? commit_ptr : wr_ptr;
    assign wr_ptr_next = wr_base + {{PTR_WIDTH{1'b0}}, wr_en};

    assign full        = (wr_ptr - rd_ptr) == FULL_DIFF;
    assign commit_full = (commit_ptr - rd_ptr) == FULL_DIFF;
    assign pending     = commit_ptr != rd_ptr;

    // The read side works from a one-cycle-delayed commit pointer.
    assign rd_valid = rd_limit != rd_ptr;
    assign rd_entry = mem[rd_ptr[PTR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_base[PTR_WIDTH-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            rd_limit   <= '0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_limit <= commit_ptr;
            if (commit) begin
                commit_ptr <= wr_ptr_next;
            end
            if (rd_valid && rd_ready) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/jellyvl_etherneco_packet_forwarder.sv
// Store-and-forward relay for an etherneco ring slave node.
// Ports: s_rx_* byte stream in (no backpressure), loopback route select,
// m_down_tx_* / m_up_tx_* ready/valid outputs, drop/pass counters, busy.
module jellyvl_etherneco_packet_forwarder
    import jellyvl_etherneco_forwarder_pkg::*;
#(
    parameter int PTR_WIDTH     = 10,
    parameter int ID_OFFSET     = 0,
    parameter int ID_INC        = 1,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     loopback,
    input  logic                     s_rx_first,
    input  logic                     s_rx_last,
    input  logic [7:0]               s_rx_data,
    input  logic                     s_rx_valid,
    output logic                     m_down_tx_first,
    output logic                     m_down_tx_last,
    output logic [7:0]               m_down_tx_data,
    output logic                     m_down_tx_valid,
    input  logic                     m_down_tx_ready,
    output logic                     m_up_tx_first,
    output logic                     m_up_tx_last,
    output logic [7:0]               m_up_tx_data,
    output logic                     m_up_tx_valid,
    input  logic                     m_up_tx_ready,
    output logic [COUNTER_WIDTH-1:0] drop_count,
    output logic [COUNTER_WIDTH-1:0] pass_count,
    output logic                     busy
);

    localparam int IDX_WIDTH = $clog2(ID_OFFSET + 2);
    localparam logic [IDX_WIDTH-1:0] ID_IDX  = IDX_WIDTH'(ID_OFFSET);
    localparam logic [IDX_WIDTH-1:0] IDX_SAT = IDX_WIDTH'(ID_OFFSET + 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);
    localparam logic [7:0]           INC     = 8'(ID_INC);

    wr_state_t            state;
    wr_state_t            state_next;
    logic                 dest_q;
    logic                 dest_next;
    logic [IDX_WIDTH-1:0] byte_idx;
    logic [IDX_WIDTH-1:0] byte_idx_next;
    logic [IDX_WIDTH-1:0] wr_idx;
    logic                 wr_dest;
    logic                 wr_en;
    logic                 commit;
    logic                 rollback;
    logic [1:0]           drop_inc;
    logic                 pass_inc;

    logic                 full;
    logic                 commit_full;
    logic                 pending;
    fifo_entry_t          wr_entry;
    fifo_entry_t          rd_entry;
    logic                 rd_valid;
    logic                 rd_ready;

    logic                 out_valid;
    logic                 out_first;
    logic                 out_last;
    logic                 out_dest;
    logic [7:0]           out_data;
    logic                 next_first;
    logic                 out_ready;
    logic                 sel_down;
    logic                 sel_up;

    always_comb begin
        state_next    = state;
        dest_next     = dest_q;
        byte_idx_next = byte_idx;
        wr_idx        = byte_idx;
        wr_dest       = dest_q;
        wr_en         = 1'b0;
        commit        = 1'b0;
        rollback      = 1'b0;
        drop_inc      = 2'd0;
        pass_inc      = 1'b0;
        if (s_rx_valid && s_rx_first) begin
            // A first byte always opens a new packet; an unfinished
            // packet in RECV is abandoned and its bytes rewound.
            rollback      = (state == RECV);
            drop_inc      = {1'b0, state == RECV};
            wr_dest       = loopback;
            dest_next     = loopback;
            wr_idx        = '0;
            byte_idx_next = IDX_ONE;
            if (commit_full) begin
                drop_inc   = drop_inc + 2'd1;
                state_next = s_rx_last ? IDLE : DROP;
            end else begin
                wr_en      = 1'b1;
                commit     = s_rx_last;
                pass_inc   = s_rx_last;
                state_next = s_rx_last ? IDLE : RECV;
            end
        end else if (s_rx_valid) begin
            unique case (state)
                RECV: begin
                    if (full) begin
                        rollback   = 1'b1;
                        drop_inc   = 2'd1;
                        state_next = s_rx_last ? IDLE : DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (byte_idx != IDX_SAT) begin
                            byte_idx_next = byte_idx + IDX_ONE;
                        end
                        if (s_rx_last) begin
                            commit     = 1'b1;
                            pass_inc   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (s_rx_last) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dest_q     <= 1'b0;
            byte_idx   <= '0;
            drop_count <= '0;
            pass_count <= '0;
        end else begin
            state      <= state_next;
            dest_q     <= dest_next;
            byte_idx   <= byte_idx_next;
            drop_count <= drop_count + COUNTER_WIDTH'(drop_inc);
            pass_count <= pass_count + COUNTER_WIDTH'(pass_inc);
        end
    end

    assign wr_entry.data = (wr_idx == ID_IDX) ? s_rx_data + INC : s_rx_data;
    assign wr_entry.last = s_rx_last;
    assign wr_entry.dest = wr_dest;

    jellyvl_etherneco_packet_fifo #(
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .reset       (reset),
        .clk         (clk),
        .wr_en       (wr_en),
        .wr_entry    (wr_entry),
        .commit      (commit),
        .rollback    (rollback),
        .full        (full),
        .commit_full (commit_full),
        .pending     (pending),
        .rd_entry    (rd_entry),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready)
    );

    assign out_ready = out_dest ? m_up_tx_ready : m_down_tx_ready;
    assign rd_ready  = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_dest   <= 1'b0;
            out_data   <= 8'h00;
            next_first <= 1'b1;
        end else if (rd_ready) begin
            out_valid <= rd_valid;
            if (rd_valid) begin
                out_data   <= rd_entry.data;
                out_last   <= rd_entry.last;
                out_dest   <= rd_entry.dest;
                out_first  <= next_first;
                next_first <= rd_entry.last;
            end
        end
    end

    assign sel_down = out_valid && !out_dest;
    assign sel_up   = out_valid && out_dest;

    assign m_down_tx_valid = sel_down;
    assign m_down_tx_first = sel_down && out_first;
    assign m_down_tx_last  = sel_down && out_last;
    assign m_down_tx_data  = sel_down ? out_data : 8'h00;

    assign m_up_tx_valid = sel_up;
    assign m_up_tx_first = sel_up && out_first;
    assign m_up_tx_last  = sel_up && out_last;
    assign m_up_tx_data  = sel_up ? out_data : 8'h00;

    assign busy = (state != IDLE) || pending || out_valid;

endmodule

// File: tb/tb_jellyvl_etherneco_packet_forwarder.sv
// Bench for the etherneco packet forwarder: two instances with different
// depth / id offset share stimulus and are checked against a packet model.
module tb_jellyvl_etherneco_packet_forwarder;

    localparam int DEPTH [2] = '{8, 16};
    localparam int OFFS  [2] = '{0, 2};
    localparam int INCS  [2] = '{1, 5};

    logic        clk;
    logic        reset;
    logic        loopback;
    logic        s_rx_first;
    logic        s_rx_last;
    logic [7:0]  s_rx_data;
    logic        s_rx_valid;
    logic        down_ready;
    logic        up_ready;

    logic        a_down_first, a_down_last, a_down_valid;
    logic [7:0]  a_down_data;
    logic        a_up_first, a_up_last, a_up_valid;
    logic [7:0]  a_up_data;
    logic [15:0] a_drop, a_pass;
    logic        a_busy;

    logic        b_down_first, b_down_last, b_down_valid;
    logic [7:0]  b_down_data;
    logic        b_up_first, b_up_last, b_up_valid;
    logic [7:0]  b_up_data;
    logic [15:0] b_drop, b_pass;
    logic        b_busy;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q [4][$];
    int         pass_exp [2];
    int         drop_exp [2];
    logic [7:0] pkt_buf [64];
    bit         rnd_ready = 0;

    jellyvl_etherneco_packet_forwarder #(
        .PTR_WIDTH (3), .ID_OFFSET (0), .ID_INC (1), .COUNTER_WIDTH (16)
    ) u_a (
        .reset (reset), .clk (clk), .loopback (loopback),
        .s_rx_first (s_rx_first), .s_rx_last (s_rx_last),
        .s_rx_data (s_rx_data), .s_rx_valid (s_rx_valid),
        .m_down_tx_first (a_down_first), .m_down_tx_last (a_down_last),
        .m_down_tx_data (a_down_data), .m_down_tx_valid (a_down_valid),
        .m_down_tx_ready (down_ready),
        .m_up_tx_first (a_up_first), .m_up_tx_last (a_up_last),
        .m_up_tx_data (a_up_data), .m_up_tx_valid (a_up_valid),
        .m_up_tx_ready (up_ready),
        .drop_count (a_drop), .pass_count (a_pass), .busy (a_busy)
    );

    jellyvl_etherneco_packet_forwarder #(
        .PTR_WIDTH (4), .ID_OFFSET (2), .ID_INC (5), .COUNTER_WIDTH (16)
    ) u_b (
        .reset (reset), .clk (clk), .loopback (loopback),
        .s_rx_first (s_rx_first), .s_rx_last (s_rx_last),
        .s_rx_data (s_rx_data), .s_rx_valid (s_rx_valid),
        .m_down_tx_first (b_down_first), .m_down_tx_last (b_down_last),
        .m_down_tx_data (b_down_data), .m_down_tx_valid (b_down_valid),
        .m_down_tx_ready (down_ready),
        .m_up_tx_first (b_up_first), .m_up_tx_last (b_up_last),
        .m_up_tx_data (b_up_data), .m_up_tx_valid (b_up_valid),
        .m_up_tx_ready (up_ready),
        .drop_count (b_drop), .pass_count (b_pass), .busy (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // streams: 0 a_down, 1 a_up, 2 b_down, 3 b_up
    logic [3:0] mv, mf, ml, mr;
    logic [7:0] md [4];
    logic [3:0] stall_q;
    logic [9:0] held_q [4];

    assign mv = {b_up_valid, b_down_valid, a_up_valid, a_down_valid};
    assign mf = {b_up_first, b_down_first, a_up_first, a_down_first};
    assign ml = {b_up_last, b_down_last, a_up_last, a_down_last};
    assign mr = {up_ready, down_ready, up_ready, down_ready};
    assign md[0] = a_down_data;
    assign md[1] = a_up_data;
    assign md[2] = b_down_data;
    assign md[3] = b_up_data;

    always @(negedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin : mon
                logic [10:0] e;
                if (stall_q[i]) begin
                    check($sformatf("hold%0d", i),
                          {mv[i], mf[i], ml[i], md[i]}, {1'b1, held_q[i]});
                end
                if (mv[i] && mr[i]) begin
                    e = 11'h400;
                    if (exp_q[i].size() != 0) e = {1'b0, exp_q[i].pop_front()};
                    check($sformatf("out%0d", i),
                          {1'b0, mf[i], ml[i], md[i]}, e);
                end
                stall_q[i] <= mv[i] & ~mr[i];
                held_q[i]  <= {mf[i], ml[i], md[i]};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) begin
                down_ready = ($urandom_range(0, 3) != 0);
                up_ready   = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic model_pkt(input int len, input bit lb, input bit has_last);
        for (int k = 0; k < 2; k++) begin
            if (has_last && len <= DEPTH[k]) begin
                for (int i = 0; i < len; i++) begin : byt
                    logic [7:0] d;
                    d = (i == OFFS[k]) ? 8'(pkt_buf[i] + INCS[k]) : pkt_buf[i];
                    exp_q[k*2 + int'(lb)].push_back({i == 0, i == len - 1, d});
                end
                pass_exp[k]++;
            end else begin
                drop_exp[k]++;
            end
        end
    endtask

    task automatic send_pkt(input int len, input bit lb, input bit has_last,
                            input bit gaps);
        for (int i = 0; i < len; i++) begin
            s_rx_valid = 1'b1;
            s_rx_first = (i == 0);
            s_rx_last  = has_last && (i == len - 1);
            s_rx_data  = pkt_buf[i];
            loopback   = (i == 0) ? lb : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            s_rx_valid = 1'b0;
            s_rx_first = 1'b0;
            s_rx_last  = 1'b0;
            s_rx_data  = 8'($urandom_range(0, 255));
            if (gaps && i < len - 1 && $urandom_range(0, 3) == 0) begin
                s_rx_first = 1'($urandom_range(0, 1));
                s_rx_last  = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                s_rx_first = 1'b0;
                s_rx_last  = 1'b0;
            end
        end
        model_pkt(len, lb, has_last);
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) pkt_buf[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((a_busy || b_busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle", {31'b0, a_busy | b_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pass_a"}, a_pass, 16'(pass_exp[0]));
        check({tag, "_drop_a"}, a_drop, 16'(drop_exp[0]));
        check({tag, "_pass_b"}, b_pass, 16'(pass_exp[1]));
        check({tag, "_drop_b"}, b_drop, 16'(drop_exp[1]));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_out_a"}, {a_down_valid, a_down_first, a_down_last,
              a_down_data, a_up_valid, a_up_first, a_up_last, a_up_data}, 0);
        check({tag, "_out_b"}, {b_down_valid, b_down_first, b_down_last,
              b_down_data, b_up_valid, b_up_first, b_up_last, b_up_data}, 0);
        check({tag, "_busy"}, {a_busy, b_busy}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] f0;
        int len;
        reset      = 1'b1;
        loopback   = 1'b0;
        s_rx_first = 1'b0;
        s_rx_last  = 1'b0;
        s_rx_data  = 8'h00;
        s_rx_valid = 1'b0;
        down_ready = 1'b1;
        up_ready   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pass_exp[k] = 0;
            drop_exp[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_quiet("rst");
        check_counters("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 4-byte packet downstream, with latency check
        for (int i = 0; i < 4; i++) pkt_buf[i] = 8'(8'h10 + i);
        send_pkt(4, 1'b0, 1'b1, 1'b0);
        check("lat_n", {a_down_valid, b_down_valid}, 0);
        @(posedge clk);
        #1;
        check("lat_n1", {a_down_valid, b_down_valid}, 0);
        @(posedge clk);
        #1;
        check("lat_n2_a", {a_down_valid, a_down_first, a_down_data}, 10'h311);
        check("lat_n2_b", {b_down_valid, b_down_first, b_down_data}, 10'h310);
        wait_idle();
        check("t1_pass_a", a_pass, 16'd1);
        check_counters("t1");

        // loopback
        for (int i = 0; i < 4; i++) pkt_buf[i] = 8'(8'h10 + i);
        send_pkt(4, 1'b1, 1'b1, 1'b0);
        wait_idle();
        check_counters("t2");

        // oversize packet then short packet
        fill_random(9);
        send_pkt(9, 1'b0, 1'b1, 1'b0);
        fill_random(3);
        send_pkt(3, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check("t3_drop_a", a_drop, 16'd1);
        check_counters("t3");

        // stalled downstream with two packets queued
        down_ready = 1'b0;
        fill_random(3);
        f0 = pkt_buf[0];
        send_pkt(3, 1'b0, 1'b1, 1'b0);
        fill_random(4);
        send_pkt(4, 1'b0, 1'b1, 1'b0);
        repeat (13) @(posedge clk);
        #1;
        check("t4_stall_a", {a_down_valid, a_down_first, a_down_data},
              {2'b11, 8'(f0 + 8'd1)});
        check("t4_stall_b", {b_down_valid, b_down_first, b_down_data},
              {2'b11, f0});
        down_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("t4_b2b", {a_down_valid, b_down_valid}, 2'b11);
        end
        wait_idle();
        check_counters("t4");

        // missing last: new first after two bytes
        fill_random(2);
        send_pkt(2, 1'b0, 1'b0, 1'b0);
        fill_random(4);
        send_pkt(4, 1'b1, 1'b1, 1'b0);
        wait_idle();
        check_counters("t5");

        // single-byte packet
        pkt_buf[0] = 8'hAA;
        send_pkt(1, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_a", {a_down_valid, a_down_first, a_down_last, a_down_data},
              {3'b111, 8'hAB});
        check("t6_b", {b_down_valid, b_down_first, b_down_last, b_down_data},
              {3'b111, 8'hAA});
        wait_idle();
        check_counters("t6");

        // randomized packets, lengths, aborts and ready patterns
        rnd_ready = 1;
        for (int p = 0; p < 60; p++) begin
            wait_idle();
            if ($urandom_range(0, 7) == 0) begin
                len = $urandom_range(1, 20);
                fill_random(len);
                send_pkt(len, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            end
            len = $urandom_range(1, 20);
            fill_random(len);
            send_pkt(len, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        rnd_ready  = 0;
        @(posedge clk);
        #1;
        down_ready = 1'b1;
        up_ready   = 1'b1;
        wait_idle();
        check_counters("rnd");

        // reset while a packet is held at the output and another is arriving
        down_ready = 1'b0;
        fill_random(3);
        send_pkt(3, 1'b0, 1'b1, 1'b0);
        fill_random(2);
        send_pkt(2, 1'b0, 1'b0, 1'b0);
        check("t8_pre", {a_down_valid, b_down_valid}, 2'b11);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        for (int k = 0; k < 2; k++) begin
            pass_exp[k] = 0;
            drop_exp[k] = 0;
        end
        check_quiet("t8");
        check_counters("t8");
        reset      = 1'b0;
        down_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_rx_valid = 1'b1;
            s_rx_last  = (i == 2);
            s_rx_data  = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        s_rx_valid = 1'b0;
        s_rx_last  = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_quiet("t8_post");
        check_counters("t8_post");

        for (int i = 0; i < 4; i++) begin
            check($sformatf("left%0d", i), exp_q[i].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jellyvl_etherneco_packet_forwarder.md
Name: jellyvl_etherneco_packet_forwarder

Overview:
- Store-and-forward relay for an etherneco ring slave node.
- Accepts the upstream rx byte stream, which has no backpressure, and buffers whole packets.
- On the way through, it rewrites a node-id byte, then sends each packet either downstream or back upstream (loopback), using ready/valid tx handshakes.
- It sits between the rx framer and the tx MACs and generalises the fixed pass-through path with depth, offset and mode parameters, drop handling and counters.

Parameters:
- PTR_WIDTH, 10: FIFO depth is 2**PTR_WIDTH bytes.
- ID_OFFSET, 0: byte index (from first) of the node-id field.
- ID_INC, 1: value added to the node-id byte, mod 256.
- COUNTER_WIDTH, 16: width of the statistics counters.

Ports:
- reset  input  1  synchronous, active-high
- clk  input  1  single clock
- loopback  input  1  0 = send downstream, 1 = return upstream; sampled on the rx first byte
- s_rx_first  input  1  first byte of packet
- s_rx_last  input  1  last byte of packet
- s_rx_data  input  8  byte
- s_rx_valid  input  1  byte strobe; no ready
- m_down_tx_first / m_down_tx_last  output  1  downstream framing
- m_down_tx_data  output  8  downstream byte
- m_down_tx_valid  output  1  downstream valid
- m_down_tx_ready  input  1  downstream ready
- m_up_tx_first / m_up_tx_last / m_up_tx_data / m_up_tx_valid / m_up_tx_ready  same as the down port, toward upstream
- drop_count  output  COUNTER_WIDTH  packets discarded, wraps
- pass_count  output  COUNTER_WIDTH  packets committed, wraps
- busy  output  1  a packet is being written or the FIFO is not empty

Behaviour:
- Reset values: all m_*_valid, first, last and data = 0; counters = 0; busy = 0; FIFO empty; write state = IDLE.
- FIFO entry fields: data[8], last, dest. Pointers are PTR_WIDTH+1 bits.
  - full = (wr_ptr - rd_ptr) == 2**PTR_WIDTH.
  - The read side sees only commit_ptr, never the speculative wr_ptr.
- Write FSM, IDLE state:
  - valid & first: write the byte, latch dest = loopback, byte_idx = 1, go to RECV.
  - valid & !first: ignore the byte.
- Write FSM, RECV state:
  - Each valid byte is written and byte_idx increments; byte_idx saturates at ID_OFFSET+1.
  - valid & last: commit_ptr <= wr_ptr+1 in the same edge, pass_count++, go to IDLE.
- Write FSM, DROP state:
  - Discard bytes until valid & last, then go to IDLE.
- Single-byte packet (first & last together): written and committed in one cycle.
- Node-id rewrite: the byte whose index == ID_OFFSET is written as (data + ID_INC) mod 256. Packets shorter than ID_OFFSET+1 bytes pass unmodified.
- Overflow:
  - valid while full: wr_ptr <= commit_ptr (rollback), drop_count++, go to DROP.
  - If the overflowing byte is also last: roll back, count the drop, go to IDLE.
  - Packets longer than 2**PTR_WIDTH bytes are always dropped.
- Missing last: a valid first while in RECV or DROP means the previous packet is lost.
  - If in RECV: roll back, drop_count++.
  - In both states: start the new packet in the same cycle, as in IDLE.
- Latency: last byte written at edge N → commit visible N+1 → first byte on the selected m_*_valid at N+2, given that port was idle.
- Read side:
  - One registered output stage. The entry's dest routes it: dest 0 → down port, dest 1 → up port.
  - The non-selected port keeps valid = 0.
  - m_*_first = 1 on the first entry after a last entry, or after reset.
  - Handshake: an entry pops on valid & ready. While valid & !ready, first/last/data/valid hold.
  - Back-to-back packets are allowed with no bubble; packets are sent in order even when dests differ.
- A read and a write in the same cycle are allowed at any fill level, including full → full-1 with a new byte. Full is evaluated pre-pop, so an overflow there is still declared.
- busy = (state != IDLE) | (commit_ptr != rd_ptr) | output stage valid.
- Reset asserted mid-packet: everything is flushed, outputs go to 0 next cycle, and no partial packet is emitted.

Decomposition:
- Package jellyvl_etherneco_forwarder_pkg: fifo_entry_t struct {data, last, dest} and the write-state enum {IDLE, RECV, DROP}.
- Sub-module jellyvl_etherneco_packet_fifo: commit/rollback FIFO with write, commit and rollback strobes, and pop with ready/valid.
- The top holds the write FSM, id rewrite, routing and counters.

Test Plan:
- 4-byte packet 10 11 12 13, ID_OFFSET=0, loopback=0, ready=1 → down port emits 11 11 12 13, first on byte 0, last on byte 3; first valid 2 cycles after the rx last; pass_count=1.
- Same packet with loopback=1 → up port emits it; down valid stays 0.
- PTR_WIDTH=3, send a 9-byte packet then a 3-byte packet, ready=1 → drop_count=1; only the 3-byte packet appears.
- down ready=0 for 20 cycles while 2 packets arrive → outputs hold stable; after release both are emitted back-to-back with correct first/last.
- A first arrives mid-packet after 2 bytes with no last → drop_count=1; the new packet forwards intact.
- Single-byte packet AA with ID_INC=1 → AB with first=last=1; with ID_OFFSET=2 it passes as AA. Reset mid-transmit → valid=0 next cycle, counters=0.
